debug_uart_tx: RTL and testbench

Buffered, transmit-only 8N1 UART for the on-chip debugger. The debug coprocessor queues reply bytes into an internal FIFO without waiting on per-byte handshakes, and the block serialises them LSB-first onto TXD. It is the write-side counterpart of the half-duplex debug UART receive path. It owns its own baud generator, so it can stream multi-byte replies back-to-back with no idle gap between frames.

---
 rtl/debug_uart_tx.sv | 241 ++++++++++++++++++++++++
 tb/tb_debug_uart_tx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/debug_uart_tx.sv
// debug_uart_tx: buffered, transmit-only 8N1 UART for the on-chip debugger.
// Reply bytes are queued in a small circular FIFO and serialised LSB-first on
// TXD by a self-timed frame FSM. Consecutive queued bytes go out with no idle
// gap between frames.
// Optional feature: define DEBUG_UART_TX_PARITY_EN to insert an even-parity
// bit between the data bits and the stop bit (11-bit frames).
module debug_uart_tx #(
   parameter int BAUD_PERIOD = 217,  // clk cycles per bit, 2..10000
   parameter int FIFO_DEPTH  = 8     // power of two, >= 2
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             sync_reset,
   input  logic                             tx_enable,
   input  logic [7:0]                       data_in,
   input  logic                             data_valid,
   output logic                             data_ready,
   output logic                             TXD,
   output logic                             busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
   output logic                             tx_done_pulse
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int BAUD_W = $clog2(BAUD_PERIOD);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
`ifdef DEBUG_UART_TX_PARITY_EN
      ST_PARITY,
`endif
      ST_STOP
   } state_t;

   // FIFO
   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             push;
   logic             pop;
   logic             fifo_has_data;
   logic [7:0]       head;

   // Frame engine
   state_t           state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             txd_q, txd_d;
   logic             done;
   logic             bit_end;
`ifdef DEBUG_UART_TX_PARITY_EN
   logic             parity_q, parity_d;
`endif

   // Fullness is judged on the registered count, so a full FIFO refuses a
   // write even in a cycle where it also pops.
   assign data_ready    = (count_q != CNT_W'(FIFO_DEPTH));
   assign fifo_has_data = (count_q != '0);
   assign push          = data_valid && data_ready && !sync_reset;
   assign head          = mem[rd_ptr_q];
   assign bit_end       = (baud_q == BAUD_W'(BAUD_PERIOD - 1));

   // FIFO storage: written only on accepted pushes.
   // NOTE: the storage array has no reset; its contents are only ever read
   // behind the occupancy counter, so resetting it would buy nothing.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= data_in;
      end
   end

   // FIFO pointers and occupancy counter; pointers wrap naturally.
   // NOTE: all clocked state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (sync_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Next-state, baud/bit counters, shift register and next TXD level.
   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      txd_d    = txd_q;
      pop      = 1'b0;
      done     = 1'b0;
`ifdef DEBUG_UART_TX_PARITY_EN
      parity_d = parity_q;
`endif

      case (state_q)
         ST_IDLE: begin
            baud_d = '0;
            txd_d  = 1'b1;
            if (fifo_has_data && tx_enable) begin
               pop     = 1'b1;
               state_d = ST_START;
               txd_d   = 1'b0;
            end
         end

         ST_START: begin
            if (bit_end) begin
               state_d = ST_DATA;
               baud_d  = '0;
               bit_d   = 3'd0;
               txd_d   = shift_q[0];
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end

         ST_DATA: begin
            if (bit_end) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
`ifdef DEBUG_UART_TX_PARITY_EN
                  state_d = ST_PARITY;
                  txd_d   = parity_q;
`else
                  state_d = ST_STOP;
                  txd_d   = 1'b1;
`endif
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = shift_q >> 1;
                  txd_d   = shift_q[1];
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end

`ifdef DEBUG_UART_TX_PARITY_EN
         ST_PARITY: begin
            if (bit_end) begin
               state_d = ST_STOP;
               baud_d  = '0;
               txd_d   = 1'b1;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
`endif

         ST_STOP: begin
            if (bit_end) begin
               done   = 1'b1;
               baud_d = '0;
               if (fifo_has_data && tx_enable) begin
                  pop     = 1'b1;
                  state_d = ST_START;
                  txd_d   = 1'b0;
               end else begin
                  state_d = ST_IDLE;
                  txd_d   = 1'b1;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
            baud_d  = '0;
            txd_d   = 1'b1;
         end
      endcase

      // A pop always loads the head byte for the frame about to start.
      if (pop) begin
         shift_d  = head;
`ifdef DEBUG_UART_TX_PARITY_EN
         parity_d = ^head;
`endif
      end
   end

   // Frame engine registers; TXD is registered and forced high by reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         txd_q    <= 1'b1;
`ifdef DEBUG_UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else if (sync_reset) begin
         state_q  <= ST_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         txd_q    <= 1'b1;
`ifdef DEBUG_UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         txd_q    <= txd_d;
`ifdef DEBUG_UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   assign TXD           = txd_q;
   assign busy          = (state_q != ST_IDLE);
   assign fifo_count    = count_q;
   // A frame being cleared by sync_reset never reports completion.
   assign tx_done_pulse = done && !sync_reset;

endmodule

// File: tb/tb_debug_uart_tx.sv
// tb_debug_uart_tx: directed self-checking bench for debug_uart_tx with
// BAUD_PERIOD=4 and FIFO_DEPTH=8. Expected frames are built from the byte
// value (start, LSB-first data, optional even parity, stop).
module tb_debug_uart_tx;

   localparam int BP    = 4;
   localparam int DEPTH = 8;
`ifdef DEBUG_UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif

   logic       clk = 1'b0;
   logic       reset_n;
   logic       sync_reset;
   logic       tx_enable;
   logic [7:0] data_in;
   logic       data_valid;
   logic       data_ready;
   logic       TXD;
   logic       busy;
   logic [3:0] fifo_count;
   logic       tx_done_pulse;

   int n_checks = 0;
   int n_fail   = 0;

   debug_uart_tx #(
      .BAUD_PERIOD(BP),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .sync_reset   (sync_reset),
      .tx_enable    (tx_enable),
      .data_in      (data_in),
      .data_valid   (data_valid),
      .data_ready   (data_ready),
      .TXD          (TXD),
      .busy         (busy),
      .fifo_count   (fifo_count),
      .tx_done_pulse(tx_done_pulse)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One write request across the next rising edge; returns on the negedge.
   task automatic write_byte(input logic [7:0] b);
      data_in    = b;
      data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
   endtask

   // Checks a whole frame whose first cycle follows the next rising edge.
   task automatic expect_frame(input logic [7:0] b, input string tag);
      logic exp_bits [FRAME_BITS];
      exp_bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) exp_bits[i+1] = b[i];
`ifdef DEBUG_UART_TX_PARITY_EN
      exp_bits[9] = ^b;
`endif
      exp_bits[FRAME_BITS-1] = 1'b1;
      for (int c = 0; c < FRAME_BITS * BP; c++) begin
         @(negedge clk);
         check({tag, " txd"},  32'(TXD),           32'(exp_bits[c / BP]));
         check({tag, " done"}, 32'(tx_done_pulse), 32'(c == FRAME_BITS * BP - 1));
         check({tag, " busy"}, 32'(busy),          32'd1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] full_bytes [9];
      int         n_done;
      int         n_low;

      full_bytes = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'hA5, 8'h3C, 8'h5A, 8'hC3, 8'h99};

      reset_n    = 1'b0;
      sync_reset = 1'b0;
      tx_enable  = 1'b1;
      data_in    = 8'h00;
      data_valid = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst txd",        32'(TXD),           32'd1);
      check("rst data_ready", 32'(data_ready),    32'd1);
      check("rst busy",       32'(busy),          32'd0);
      check("rst fifo_count", 32'(fifo_count),    32'd0);
      check("rst done",       32'(tx_done_pulse), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // Single byte 0x55: count updates at accept edge, TXD falls next edge
      write_byte(8'h55);
      check("single count", 32'(fifo_count), 32'd1);
      check("single txd",   32'(TXD),        32'd1);
      check("single busy",  32'(busy),       32'd0);
      expect_frame(8'h55, "f55");
      @(negedge clk);
      check("single idle busy",  32'(busy),       32'd0);
      check("single idle txd",   32'(TXD),        32'd1);
      check("single idle count", 32'(fifo_count), 32'd0);

      // FIFO full with transmitter disabled: 9th write is dropped
      tx_enable = 1'b0;
      for (int i = 0; i < 9; i++) begin
         write_byte(full_bytes[i]);
         if (i == 7) begin
            check("full count",      32'(fifo_count), 32'd8);
            check("full data_ready", 32'(data_ready), 32'd0);
            check("full busy",       32'(busy),       32'd0);
         end
      end
      check("full drop count", 32'(fifo_count), 32'd8);
      tx_enable = 1'b1;
      for (int i = 0; i < 8; i++) expect_frame(full_bytes[i], $sformatf("full%0d", i));
      @(negedge clk);
      check("full drained busy",  32'(busy),       32'd0);
      check("full drained count", 32'(fifo_count), 32'd0);

      // Back-to-back 0xA5, 0x3C with a push coinciding with the first pop
      write_byte(8'hA5);
      data_in    = 8'h3C;
      data_valid = 1'b1;
      fork
         expect_frame(8'hA5, "b2b0");
         begin
            @(negedge clk);
            data_valid = 1'b0;
            check("pushpop count", 32'(fifo_count), 32'd1);
         end
      join
      expect_frame(8'h3C, "b2b1");
      @(negedge clk);
      check("b2b idle busy", 32'(busy), 32'd0);

      // tx_enable dropped mid-frame: frame completes, FIFO retained
      write_byte(8'h07);
      data_in    = 8'h03;
      data_valid = 1'b1;
      fork
         expect_frame(8'h07, "en07");
         begin
            @(negedge clk);
            data_valid = 1'b0;
            repeat (5) @(negedge clk);
            tx_enable = 1'b0;
         end
      join
      @(negedge clk);
      check("park busy",  32'(busy),       32'd0);
      check("park count", 32'(fifo_count), 32'd1);
      check("park txd",   32'(TXD),        32'd1);
      repeat (8) @(negedge clk);
      check("park hold busy",  32'(busy),       32'd0);
      check("park hold count", 32'(fifo_count), 32'd1);
      tx_enable = 1'b1;
      expect_frame(8'h03, "en03");
      @(negedge clk);

      // sync_reset mid-DATA with three bytes queued and a write pending
      write_byte(8'h00);
      write_byte(8'h22);
      write_byte(8'h33);
      write_byte(8'h44);
      repeat (4) @(negedge clk);
      check("sr pre busy",  32'(busy),       32'd1);
      check("sr pre count", 32'(fifo_count), 32'd3);
      check("sr pre txd",   32'(TXD),        32'd0);
      sync_reset = 1'b1;
      data_in    = 8'h77;
      data_valid = 1'b1;
      @(negedge clk);
      sync_reset = 1'b0;
      data_valid = 1'b0;
      check("sr txd",        32'(TXD),           32'd1);
      check("sr busy",       32'(busy),          32'd0);
      check("sr count",      32'(fifo_count),    32'd0);
      check("sr done",       32'(tx_done_pulse), 32'd0);
      check("sr data_ready", 32'(data_ready),    32'd1);
      n_done = 0;
      n_low  = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (tx_done_pulse) n_done++;
         if (!TXD) n_low++;
      end
      check("sr no done pulse", 32'(n_done), 32'd0);
      check("sr line idle",     32'(n_low),  32'd0);

      // reset_n mid-DATA: TXD forced high without waiting for an edge
      write_byte(8'h00);
      write_byte(8'h22);
      write_byte(8'h33);
      write_byte(8'h44);
      repeat (4) @(negedge clk);
      check("ar pre txd", 32'(TXD), 32'd0);
      #2;
      reset_n = 1'b0;
      #1;
      check("ar txd",   32'(TXD),        32'd1);
      check("ar busy",  32'(busy),       32'd0);
      check("ar count", 32'(fifo_count), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("ar post txd",  32'(TXD),  32'd1);
      check("ar post busy", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
